// File: rtl/tjmono2_rx_merger.sv
// tjmono2_rx_merger: per-lane 24-bit hit assembly from decoded 8b10b bytes,
// per-lane hit buffering with optional timestamp, and a round-robin merge of
// all lanes into one tagged 32-bit readout stream with per-lane loss tracking.
module tjmono2_rx_merger #(
    parameter int unsigned NUM_CH          = 4,
    parameter logic [3:0]  DATA_IDENTIFIER = 4'd0,
    parameter int unsigned CH_FIFO_DEPTH   = 8
) (
    input  logic                  BUS_CLK,
    input  logic                  BUS_RST,
    input  logic [NUM_CH-1:0]     ENABLE,
    input  logic                  TS_MODE,
    input  logic [8*NUM_CH-1:0]   RX_BYTE,
    input  logic [NUM_CH-1:0]     RX_K,
    input  logic [NUM_CH-1:0]     RX_VALID,
    input  logic [26:0]           TIMESTAMP,
    output logic [31:0]           OUT_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [8*NUM_CH-1:0]   LOST_CNT,
    output logic [NUM_CH-1:0]     OVERFLOW,
    input  logic                  CLEAR_ERR
);

    localparam int unsigned AW = $clog2(CH_FIFO_DEPTH);
    // Buffer entry: {payload[23:0], timestamp[26:0], ts_mode}
    localparam int unsigned EW = 52;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIT,
        ST_TS
    } state_t;

    // Per-lane assembler state
    logic [1:0]    idx_q [NUM_CH];
    logic [1:0]    idx_d [NUM_CH];
    logic [15:0]   shr_q [NUM_CH];
    logic [15:0]   shr_d [NUM_CH];

    // Per-lane buffers
    logic [EW-1:0] mem_q  [NUM_CH][CH_FIFO_DEPTH];
    logic [EW-1:0] mem_d  [NUM_CH][CH_FIFO_DEPTH];
    logic [AW:0]   wptr_q [NUM_CH];
    logic [AW:0]   wptr_d [NUM_CH];
    logic [AW:0]   rptr_q [NUM_CH];
    logic [AW:0]   rptr_d [NUM_CH];
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] fifo_full;
    logic [NUM_CH-1:0] pop;

    // Error tracking
    logic [7:0]        lost_q [NUM_CH];
    logic [7:0]        lost_d [NUM_CH];
    logic [NUM_CH-1:0] ovf_q;
    logic [NUM_CH-1:0] ovf_d;

    // Arbiter and output register
    state_t      state_q, state_d;
    logic [2:0]  ptr_q, ptr_d;
    logic [2:0]  ch_q, ch_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic [26:0] ts_q, ts_d;
    logic        tsf_q, tsf_d;

    // Arbiter scratch
    logic          load;
    logic          found;
    int unsigned   start_ch;
    int unsigned   cand;
    int unsigned   sel;
    logic [EW-1:0] rd_entry;

    // Assembler scratch
    logic [7:0]    cur_byte;
    logic          lost_inc;
    logic          ovf_set;

    function automatic logic [2:0] next_ch(input logic [2:0] c);
        if (32'(c) >= NUM_CH - 1)
            return 3'd0;
        return c + 3'd1;
    endfunction

    // Buffer occupancy flags from the registered pointers
    always_comb begin
        fifo_empty = '0;
        fifo_full  = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            fifo_empty[c] = (wptr_q[c] == rptr_q[c]);
            fifo_full[c]  = (wptr_q[c][AW] != rptr_q[c][AW]) &&
                            (wptr_q[c][AW-1:0] == rptr_q[c][AW-1:0]);
        end
    end

    // Arbiter next state: finish the current transfer, then search and pop in the same cycle
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        ch_d        = ch_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        ts_d        = ts_q;
        tsf_d       = tsf_q;
        pop         = '0;
        load        = 1'b0;
        found       = 1'b0;
        start_ch    = 32'(ptr_q);
        cand        = 0;
        sel         = 0;
        rd_entry    = '0;

        case (state_q)
            ST_IDLE: begin
                load = 1'b1;
            end
            ST_HIT: begin
                if (OUT_READY) begin
                    if (tsf_q) begin
                        state_d    = ST_TS;
                        out_data_d = {DATA_IDENTIFIER, 1'b1, ts_q};
                    end else begin
                        ptr_d    = next_ch(ch_q);
                        start_ch = 32'(next_ch(ch_q));
                        load     = 1'b1;
                    end
                end
            end
            ST_TS: begin
                if (OUT_READY) begin
                    ptr_d    = next_ch(ch_q);
                    start_ch = 32'(next_ch(ch_q));
                    load     = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        if (load) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cand = start_ch + i;
                if (cand >= NUM_CH)
                    cand = cand - NUM_CH;
                if (!found && !fifo_empty[cand]) begin
                    found = 1'b1;
                    sel   = cand;
                end
            end
            if (found) begin
                pop[sel]    = 1'b1;
                rd_entry    = mem_q[sel][rptr_q[sel][AW-1:0]];
                out_data_d  = {DATA_IDENTIFIER, 1'b0, 3'(sel), rd_entry[51:28]};
                ts_d        = rd_entry[27:1];
                tsf_d       = rd_entry[0];
                ch_d        = 3'(sel);
                state_d     = ST_HIT;
                out_valid_d = 1'b1;
            end else begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        end
    end

    // Per-lane byte assembly, buffer write/read pointers and loss accounting
    always_comb begin
        idx_d    = idx_q;
        shr_d    = shr_q;
        mem_d    = mem_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        lost_d   = lost_q;
        ovf_d    = ovf_q;
        cur_byte = '0;
        lost_inc = 1'b0;
        ovf_set  = 1'b0;

        for (int unsigned c = 0; c < NUM_CH; c++) begin
            cur_byte = RX_BYTE[8*c +: 8];
            lost_inc = 1'b0;
            ovf_set  = 1'b0;

            if (pop[c])
                rptr_d[c] = rptr_q[c] + 1'b1;

            if (!ENABLE[c]) begin
                idx_d[c] = 2'd0;
            end else if (RX_VALID[c]) begin
                if (RX_K[c]) begin
                    idx_d[c] = 2'd0;
                    if (cur_byte != 8'hBC && idx_q[c] != 2'd0)
                        lost_inc = 1'b1;
                end else if (idx_q[c] == 2'd2) begin
                    idx_d[c] = 2'd0;
                    // A pop this cycle frees a slot, so a full buffer still accepts the write
                    if (!fifo_full[c] || pop[c]) begin
                        mem_d[c][wptr_q[c][AW-1:0]] = {shr_q[c], cur_byte, TIMESTAMP, TS_MODE};
                        wptr_d[c] = wptr_q[c] + 1'b1;
                    end else begin
                        lost_inc = 1'b1;
                        ovf_set  = 1'b1;
                    end
                end else begin
                    shr_d[c] = {shr_q[c][7:0], cur_byte};
                    idx_d[c] = idx_q[c] + 2'd1;
                end
            end

            if (CLEAR_ERR) begin
                lost_d[c] = 8'd0;
                ovf_d[c]  = 1'b0;
            end else begin
                if (lost_inc && lost_q[c] != 8'hFF)
                    lost_d[c] = lost_q[c] + 8'd1;
                if (ovf_set)
                    ovf_d[c] = 1'b1;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                idx_q[c]  <= '0;
                shr_q[c]  <= '0;
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
                lost_q[c] <= '0;
            end
            ovf_q       <= '0;
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            ch_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ts_q        <= '0;
            tsf_q       <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            shr_q       <= shr_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            lost_q      <= lost_d;
            ovf_q       <= ovf_d;
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            ch_q        <= ch_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ts_q        <= ts_d;
            tsf_q       <= tsf_d;
        end
    end

    // Buffer storage; contents are don't-care while the pointers say empty
    always_ff @(posedge BUS_CLK) begin
        mem_q <= mem_d;
    end

    // Pack per-lane loss counters onto the output bus
    always_comb begin
        LOST_CNT = '0;
        for (int unsigned c = 0; c < NUM_CH; c++)
            LOST_CNT[8*c +: 8] = lost_q[c];
    end

    assign OUT_DATA  = out_data_q;
    assign OUT_VALID = out_valid_q;
    assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_tjmono2_rx_merger.sv
// Directed bench for tjmono2_rx_merger: 4 lanes, tag 5, 8-entry lane buffers.
module tb_tjmono2_rx_merger;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  enable;
    logic        ts_mode;
    logic [31:0] rx_byte;
    logic [3:0]  rx_k;
    logic [3:0]  rx_valid;
    logic [26:0] timestamp;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] lost_cnt;
    logic [3:0]  overflow;
    logic        clear_err;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    tjmono2_rx_merger #(
        .NUM_CH(4),
        .DATA_IDENTIFIER(4'd5),
        .CH_FIFO_DEPTH(8)
    ) dut (
        .BUS_CLK(clk),
        .BUS_RST(rst),
        .ENABLE(enable),
        .TS_MODE(ts_mode),
        .RX_BYTE(rx_byte),
        .RX_K(rx_k),
        .RX_VALID(rx_valid),
        .TIMESTAMP(timestamp),
        .OUT_DATA(out_data),
        .OUT_VALID(out_valid),
        .OUT_READY(out_ready),
        .LOST_CNT(lost_cnt),
        .OVERFLOW(overflow),
        .CLEAR_ERR(clear_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One input cycle: drive valid/K masks and the byte bus, then release
    task automatic cyc(input logic [3:0] v, input logic [3:0] k, input logic [31:0] b);
        rx_valid = v;
        rx_k     = k;
        rx_byte  = b;
        tick();
        rx_valid = '0;
        rx_k     = '0;
        rx_byte  = '0;
    endtask

    // Wait (bounded) for a word, check it, and let it transfer (OUT_READY must be 1)
    task automatic expect_word(input string tag, input logic [31:0] exp);
        int unsigned n;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check(tag, out_data, exp);
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 4'hF;
        ts_mode   = 1'b0;
        rx_byte   = '0;
        rx_k      = '0;
        rx_valid  = '0;
        timestamp = '0;
        out_ready = 1'b1;
        clear_err = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_lost", lost_cnt, 32'd0);
        check("rst_ovf", {28'd0, overflow}, 32'd0);

        // 1: single word on ch0, exact latency
        cyc(4'b0001, 4'b0, 32'h0000_0012);
        cyc(4'b0001, 4'b0, 32'h0000_0034);
        cyc(4'b0001, 4'b0, 32'h0000_0056);
        check("t1_lat_n1", {31'd0, out_valid}, 32'd0);
        tick();
        check("t1_lat_n2", {31'd0, out_valid}, 32'd1);
        check("t1_data", out_data, 32'h5012_3456);
        tick();
        check("t1_after", {31'd0, out_valid}, 32'd0);

        // 2: timestamp mode, ch2 hit+ts stay adjacent while ch1 is pending
        ts_mode   = 1'b1;
        timestamp = 27'h123_4567;
        cyc(4'b0110, 4'b0, 32'h00AB_0100);
        cyc(4'b0110, 4'b0, 32'h00CD_0200);
        cyc(4'b0100, 4'b0, 32'h00EF_0000);
        timestamp = 27'h765_4321;
        cyc(4'b0010, 4'b0, 32'h0000_0300);
        check("t2_valid", {31'd0, out_valid}, 32'd1);
        check("t2_hit2", out_data, 32'h52AB_CDEF);
        tick();
        check("t2_ts2", out_data, 32'h5923_4567);
        tick();
        check("t2_hit1", out_data, 32'h5101_0203);
        tick();
        check("t2_ts1", out_data, 32'h5F65_4321);
        tick();
        check("t2_idle", {31'd0, out_valid}, 32'd0);
        ts_mode = 1'b0;

        // 3a: bring pointer to 0 with a ch3 word, then all lanes at once
        cyc(4'b1000, 4'b0, 32'h0A00_0000);
        cyc(4'b1000, 4'b0, 32'h0B00_0000);
        cyc(4'b1000, 4'b0, 32'h0C00_0000);
        expect_word("t3_ch3", 32'h530A_0B0C);
        cyc(4'b1111, 4'b0, 32'h1312_1110);
        cyc(4'b1111, 4'b0, 32'h2322_2120);
        cyc(4'b1111, 4'b0, 32'h3332_3130);
        expect_word("t3a_0", 32'h5010_2030);
        expect_word("t3a_1", 32'h5111_2131);
        expect_word("t3a_2", 32'h5212_2232);
        expect_word("t3a_3", 32'h5313_2333);
        check("t3a_idle", {31'd0, out_valid}, 32'd0);

        // 3b: ch1 word moves pointer to 2, then all lanes again
        cyc(4'b0010, 4'b0, 32'h0000_4400);
        cyc(4'b0010, 4'b0, 32'h0000_5500);
        cyc(4'b0010, 4'b0, 32'h0000_6600);
        expect_word("t3_ch1", 32'h5144_5566);
        cyc(4'b1111, 4'b0, 32'h4342_4140);
        cyc(4'b1111, 4'b0, 32'h5352_5150);
        cyc(4'b1111, 4'b0, 32'h6362_6160);
        expect_word("t3b_2", 32'h5242_5262);
        expect_word("t3b_3", 32'h5343_5363);
        expect_word("t3b_0", 32'h5040_5060);
        expect_word("t3b_1", 32'h5141_5161);

        // 4: output stalled on a ch0 word, ch1 overflows its 8-entry buffer
        out_ready = 1'b0;
        cyc(4'b0001, 4'b0, 32'h0000_00C0);
        cyc(4'b0001, 4'b0, 32'h0000_00FF);
        cyc(4'b0001, 4'b0, 32'h0000_00EE);
        tick();
        for (int i = 0; i < 9; i++) begin
            cyc(4'b0010, 4'b0, 32'h0000_7000);
            cyc(4'b0010, 4'b0, 32'h0000_0000);
            cyc(4'b0010, 4'b0, {16'd0, 8'(i), 8'd0});
        end
        tick();
        check("t4_hold_valid", {31'd0, out_valid}, 32'd1);
        check("t4_hold_data", out_data, 32'h50C0_FFEE);
        check("t4_lost", lost_cnt, 32'h0000_0100);
        check("t4_ovf", {28'd0, overflow}, 32'h0000_0002);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("t4_clr_lost", lost_cnt, 32'd0);
        check("t4_clr_ovf", {28'd0, overflow}, 32'd0);
        out_ready = 1'b1;
        expect_word("t4_ch0", 32'h50C0_FFEE);
        for (int i = 0; i < 8; i++)
            expect_word("t4_ch1", 32'h5170_0000 | 32'(i));
        check("t4_drop9", {31'd0, out_valid}, 32'd0);

        // 5: K character mid-word on ch3
        cyc(4'b1000, 4'b0000, 32'h1100_0000);
        cyc(4'b1000, 4'b1000, 32'h3C00_0000);
        cyc(4'b1000, 4'b0000, 32'h2200_0000);
        cyc(4'b1000, 4'b0000, 32'h3300_0000);
        cyc(4'b1000, 4'b0000, 32'h4400_0000);
        expect_word("t5_k3c", 32'h5322_3344);
        check("t5_lost", lost_cnt, 32'h0100_0000);
        check("t5_ovf", {28'd0, overflow}, 32'd0);
        check("t5_only", {31'd0, out_valid}, 32'd0);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        cyc(4'b1000, 4'b0000, 32'h1100_0000);
        cyc(4'b1000, 4'b1000, 32'hBC00_0000);
        cyc(4'b1000, 4'b0000, 32'h5500_0000);
        cyc(4'b1000, 4'b0000, 32'h6600_0000);
        cyc(4'b1000, 4'b0000, 32'h7700_0000);
        expect_word("t5_kbc", 32'h5355_6677);
        check("t5_comma_lost", lost_cnt, 32'd0);

        // Disabled lane ignores its bytes
        enable = 4'b1110;
        cyc(4'b0001, 4'b0, 32'h0000_0001);
        cyc(4'b0001, 4'b0, 32'h0000_0002);
        cyc(4'b0001, 4'b0, 32'h0000_0003);
        tick();
        tick();
        check("dis_none", {31'd0, out_valid}, 32'd0);
        enable = 4'hF;

        // 6: reset while a word is presented and buffers hold data
        out_ready = 1'b0;
        cyc(4'b0111, 4'b0, 32'h0000_1201);
        cyc(4'b0101, 4'b0, 32'h0002_0002);
        cyc(4'b0101, 4'b0, 32'h0003_0003);
        tick();
        tick();
        check("t6_pre", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        tick();
        check("t6_rst", {31'd0, out_valid}, 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        check("t6_no_stale", {31'd0, out_valid}, 32'd0);
        cyc(4'b0010, 4'b0, 32'h0000_9900);
        cyc(4'b0010, 4'b0, 32'h0000_8800);
        cyc(4'b0010, 4'b0, 32'h0000_7700);
        expect_word("t6_fresh", 32'h5199_8877);
        check("t6_end", {31'd0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tjmono2_rx_merger.md
Name: tjmono2_rx_merger

Overview:
Multi-channel successor to the single-lane TJ-Monopix2 receiver back end. It takes NUM_CH already-decoded 8b10b byte streams, all in the BUS_CLK domain, and assembles each into 24-bit hit words. Each hit is buffered per channel, with an optional 27-bit timestamp. A round-robin arbiter merges all channels into one tagged 32-bit word stream that feeds the readout FIFO. Lost-word counting and overflow flags are kept per channel.

Parameters:
NUM_CH, 4, number of input lanes (1..8); channel field is always 3 bits wide.
DATA_IDENTIFIER, 0, 4-bit tag placed in out word [31:28].
CH_FIFO_DEPTH, 8, entries per channel buffer; must be a power of 2 and at least 2.

Ports:
BUS_CLK  in  1  sole clock.
BUS_RST  in  1  synchronous, active-high reset.
ENABLE  in  NUM_CH  per-channel assembler enable.
TS_MODE  in  1  1 = append a timestamp word after each hit word.
RX_BYTE  in  8*NUM_CH  decoded byte; channel c occupies [8c+7:8c].
RX_K  in  NUM_CH  K-character flag per channel.
RX_VALID  in  NUM_CH  byte strobe, one byte per cycle per channel.
TIMESTAMP  in  27  free-running timestamp.
OUT_DATA  out  32  merged word.
OUT_VALID  out  1  OUT_DATA valid.
OUT_READY  in  1  downstream accepts.
LOST_CNT  out  8*NUM_CH  per-channel dropped-word count, saturating.
OVERFLOW  out  NUM_CH  sticky per-channel overflow flag.
CLEAR_ERR  in  1  single-cycle pulse; clears LOST_CNT and OVERFLOW.

Behaviour:
- Clock and reset: one clock (BUS_CLK); reset BUS_RST is synchronous and active-high.
- Reset state: all outputs 0. All byte indices, FIFOs and the round-robin pointer are cleared; the pointer starts at 0.
- Reset mid-operation: partial words and buffered entries are discarded. OUT_VALID is 0 in the cycle after reset is sampled.
- Assembler, per channel, with byte index 0..2:
  - Only acts when ENABLE[c] && RX_VALID[c].
  - Data byte (RX_K=0): shifted in MSB first; the index increments.
  - On the 3rd byte the word completes. Entry = {payload[23:0], TIMESTAMP sampled that cycle, TS_MODE sampled that cycle}. The entry is written to the channel FIFO on the next clock edge; the index returns to 0.
  - K byte 0xBC (comma): index returns to 0. Any partial word is discarded without counting.
  - Any other K byte: index returns to 0 and the partial word is discarded. If the index was not 0, this counts as one lost word.
  - ENABLE[c]=0: index held at 0 and inputs ignored. The channel FIFO still drains.
- Overflow: a completed word arriving when the channel FIFO is full is dropped. LOST_CNT[c] increments (saturating at 255) and OVERFLOW[c] is set.
  - CLEAR_ERR takes priority over a same-cycle increment; the result is count 0 and flag 0.
- Output word formats:
  - Hit word: [31:28] DATA_IDENTIFIER, [27]=0, [26:24] channel, [23:0] payload.
  - Timestamp word: [31:28] DATA_IDENTIFIER, [27]=1, [26:0] stored TIMESTAMP.
- Arbiter FSM:
  - IDLE: search non-empty FIFOs starting at the pointer, wrapping mod NUM_CH. The first hit is popped into the output register and the FSM moves to HIT, with OUT_VALID=1.
  - HIT: on OUT_READY, go to TS if the entry's stored TS_MODE flag is 1. Otherwise set pointer = c+1 mod NUM_CH and go to IDLE. A back-to-back pop in the same cycle is permitted.
  - TS: present the timestamp word. On OUT_READY, advance the pointer and return as above.
  - A hit word and its timestamp word are never separated by another channel's word.
- Handshake: OUT_DATA is stable while OUT_VALID && !OUT_READY. The transfer happens on the cycle where OUT_VALID && OUT_READY.
- Latency: 3rd byte sampled in cycle N → entry in FIFO at N+1 → OUT_VALID=1 in cycle N+2 when the arbiter is idle.
- Throughput: with continuous OUT_READY, one word per cycle.
- Simultaneous events: a FIFO write and read in the same cycle on a full FIFO are both accepted, so no drop occurs. A FIFO write and read in the same cycle on an empty FIFO: the read sees empty and the write lands normally.
- TS_MODE changes affect only words completed after the change.

Test Plan:
1. Ch0 bytes 0x12,0x34,0x56, TS_MODE=0, OUT_READY=1, DATA_IDENTIFIER=5 → one word 0x50123456 at N+2, then OUT_VALID=0.
2. TS_MODE=1, ch2 completes 0xABCDEF with TIMESTAMP=0x1234567 → 0x52ABCDEF, then 0x59234567. The two words are adjacent even with ch1 pending.
3. Channels 0..3 each complete one word in the same cycle, OUT_READY=1 → output order ch0, ch1, ch2, ch3. A second round starting after the pointer has advanced to 2 → order ch2, ch3, ch0, ch1.
4. OUT_READY=0, ch1 sends 9 words with depth 8 → 8 are buffered, the 9th is dropped, LOST_CNT[1]=1, OVERFLOW[1]=1. A CLEAR_ERR pulse → both read 0.
5. Ch3 sends 0x11, then K 0x3C, then 0x22,0x33,0x44 → LOST_CNT[3]=1 and only payload 0x223344 is output. The same sequence using K 0xBC → LOST_CNT stays 0.
6. BUS_RST asserted while OUT_VALID=1 with FIFOs holding words → OUT_VALID=0 next cycle. After release, no stale words are output and the first new word is from a freshly completed hit.
